// File: rtl/can_rx_frame_buffer.sv
// CAN 2.0A/B receiver: destuffs sampled bits, decodes std/ext frames, checks CRC-15, drives ACK, and
// queues accepted frames in a FWFT FIFO. Define CAN_RX_ACCEPT_FILTER_EN to add acceptance filters.
module can_rx_frame_buffer #(
    parameter int FIFO_DEPTH = 8,
    parameter int NUM_FILT   = 4
) (
    input  logic                          clk_can,
    input  logic                          rst,
    input  logic                          bit_en,
    input  logic                          rx_bit,
    output logic                          ack_drive,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [28:0]                   rx_id,
    output logic                          rx_ide,
    output logic                          rx_rtr,
    output logic [3:0]                    rx_dlc,
    output logic [63:0]                   rx_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          rx_overflow,
    input  logic                          ovf_clr,
`ifdef CAN_RX_ACCEPT_FILTER_EN
    input  logic [NUM_FILT-1:0]           filt_en,
    input  logic [NUM_FILT-1:0]           filt_ide,
    input  logic [NUM_FILT*29-1:0]        filt_id,
    input  logic [NUM_FILT*29-1:0]        filt_mask,
    output logic [$clog2(NUM_FILT)-1:0]   rx_filt_hit,
`endif
    output logic                          err_stuff,
    output logic                          err_crc,
    output logic                          err_form
);
    // state | meaning
    // INTEG/ERR | waiting for 11 recessive bits     IDLE | bus idle, waiting for SOF
    // ARB/EXT_ID | base/extended ID                 CTL1 | RTR-or-SRR, IDE      EXT_CTL | RTR, r1
    // CTL | r0 + DLC    DATA | payload    CRC | CRC sequence    CRC_DEL/ACK/ACK_DEL/EOF | frame tail
    typedef enum logic [3:0] {
        INTEG, IDLE, ARB, CTL1, EXT_ID, EXT_CTL, CTL, DATA, CRC, CRC_DEL, ACK, ACK_DEL, EOF, ERR
    } state_t;

    localparam int          AW     = $clog2(FIFO_DEPTH);
    localparam logic [5:0]  REC_M1 = 6'd10;

    typedef struct packed {
        logic [28:0] id;
        logic        ide;
        logic        rtr;
        logic [3:0]  dlc;
        logic [63:0] data;
    } frame_t;

    state_t      state, state_nxt;
    logic [5:0]  cnt, cnt_nxt;
    logic        run_val;
    logic [2:0]  run_cnt;
    logic [28:0] id;
    logic        ide, rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
    logic [5:0]  data_ptr;
    logic [14:0] crc, crc_upd;
    logic        crc_bad;
    logic        stuff_zone, stuff_slot, take;
    logic        set_stuff, set_crc, set_form, ack_set, commit;
    logic [3:0]  dlc_now, nbytes;
    logic [5:0]  data_m1;

    assign stuff_zone = state inside {ARB, CTL1, EXT_ID, EXT_CTL, CTL, DATA, CRC, CRC_DEL};
    assign stuff_slot = stuff_zone && (run_cnt == 3'd5);
    assign crc_upd    = {crc[13:0], 1'b0} ^ ((crc[14] ^ rx_bit) ? 15'h4599 : 15'h0000);
    assign dlc_now    = {dlc[2:0], rx_bit};
    assign nbytes     = dlc_now[3] ? 4'd8 : {1'b0, dlc_now[2:0]};
    assign data_m1    = 6'({nbytes, 3'b000} - 7'd1);

    always_ff @(posedge clk_can) begin
        if (rst) begin
            state <= INTEG;
            cnt   <= REC_M1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        take      = 1'b0;
        set_stuff = 1'b0;
        set_crc   = 1'b0;
        set_form  = 1'b0;
        ack_set   = 1'b0;
        commit    = 1'b0;
        if (bit_en) begin
            if (stuff_slot) begin
                if (rx_bit == run_val) begin
                    set_stuff = 1'b1;
                    state_nxt = ERR;
                    cnt_nxt   = REC_M1;
                end
            end else begin
                take = 1'b1;
                unique case (state)
                    INTEG, ERR: begin
                        if (!rx_bit)          cnt_nxt = REC_M1;
                        else if (cnt == 6'd0) state_nxt = IDLE;
                        else                  cnt_nxt = cnt - 6'd1;
                    end
                    IDLE: if (!rx_bit) begin state_nxt = ARB; cnt_nxt = 6'd10; end
                    ARB: if (cnt == 6'd0) begin state_nxt = CTL1; cnt_nxt = 6'd1; end
                         else cnt_nxt = cnt - 6'd1;
                    CTL1: if (cnt == 6'd0) begin
                              state_nxt = rx_bit ? EXT_ID : CTL;
                              cnt_nxt   = rx_bit ? 6'd17 : 6'd4;
                          end else cnt_nxt = cnt - 6'd1;
                    EXT_ID: if (cnt == 6'd0) begin state_nxt = EXT_CTL; cnt_nxt = 6'd1; end
                            else cnt_nxt = cnt - 6'd1;
                    EXT_CTL: if (cnt == 6'd0) begin state_nxt = CTL; cnt_nxt = 6'd4; end
                             else cnt_nxt = cnt - 6'd1;
                    CTL: if (cnt == 6'd0) begin
                             if (rtr || dlc_now == 4'd0) begin state_nxt = CRC; cnt_nxt = 6'd14; end
                             else begin state_nxt = DATA; cnt_nxt = data_m1; end
                         end else cnt_nxt = cnt - 6'd1;
                    DATA: if (cnt == 6'd0) begin state_nxt = CRC; cnt_nxt = 6'd14; end
                          else cnt_nxt = cnt - 6'd1;
                    CRC: if (cnt == 6'd0) state_nxt = CRC_DEL;
                         else cnt_nxt = cnt - 6'd1;
                    CRC_DEL: begin
                        if (!rx_bit)      begin set_form = 1'b1; state_nxt = ERR; cnt_nxt = REC_M1; end
                        else if (crc_bad) begin set_crc  = 1'b1; state_nxt = ERR; cnt_nxt = REC_M1; end
                        else              begin ack_set  = 1'b1; state_nxt = ACK; end
                    end
                    ACK: state_nxt = ACK_DEL;
                    ACK_DEL: if (!rx_bit) begin set_form = 1'b1; state_nxt = ERR; cnt_nxt = REC_M1; end
                             else begin state_nxt = EOF; cnt_nxt = 6'd6; end
                    EOF: begin
                        // Last EOF bit is not checked: a dominant level there is an overload start.
                        if (cnt == 6'd0) state_nxt = IDLE;
                        else if (!rx_bit) begin set_form = 1'b1; state_nxt = ERR; cnt_nxt = REC_M1; end
                        else begin
                            commit  = (cnt == 6'd1);
                            cnt_nxt = cnt - 6'd1;
                        end
                    end
                    default: begin state_nxt = INTEG; cnt_nxt = REC_M1; end
                endcase
            end
        end
    end

    always_ff @(posedge clk_can) begin
        if (rst) begin
            run_val <= 1'b0; run_cnt <= 3'd0; id <= '0; ide <= 1'b0; rtr <= 1'b0; dlc <= '0;
            data <= '0; data_ptr <= '0; crc <= '0; crc_bad <= 1'b0;
        end else if (bit_en) begin
            if (state == IDLE && !rx_bit) begin
                run_val <= 1'b0; run_cnt <= 3'd1; id <= '0; ide <= 1'b0; rtr <= 1'b0; dlc <= '0;
                data <= '0; data_ptr <= '0; crc <= '0; crc_bad <= 1'b0;
            end else if (stuff_zone) begin
                if (rx_bit == run_val) run_cnt <= run_cnt + 3'd1;
                else begin run_val <= rx_bit; run_cnt <= 3'd1; end
            end
            if (take) begin
                unique case (state)
                    ARB, EXT_ID: id <= {id[27:0], rx_bit};
                    CTL1: if (cnt == 6'd1) rtr <= rx_bit; else ide <= rx_bit;
                    EXT_CTL: if (cnt == 6'd1) rtr <= rx_bit;
                    CTL: if (cnt <= 6'd3) dlc <= dlc_now;
                    DATA: begin
                        data[6'd63 - data_ptr] <= rx_bit;
                        data_ptr <= data_ptr + 6'd1;
                    end
                    default: ;
                endcase
                if (state inside {ARB, CTL1, EXT_ID, EXT_CTL, CTL, DATA, CRC}) crc <= crc_upd;
                if (state == CRC && cnt == 6'd0) crc_bad <= |crc_upd;
            end
        end
    end

    always_ff @(posedge clk_can) begin
        if (rst) begin
            ack_drive <= 1'b0; err_stuff <= 1'b0; err_crc <= 1'b0; err_form <= 1'b0;
        end else begin
            if (bit_en) ack_drive <= ack_set;
            err_stuff <= set_stuff;
            err_crc   <= set_crc;
            err_form  <= set_form;
        end
    end

    logic          filt_pass, full, pop, push, ovf_set;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level;
    frame_t        mem [FIFO_DEPTH];
    frame_t        head;

`ifdef CAN_RX_ACCEPT_FILTER_EN
    localparam int FW = $clog2(NUM_FILT);
    logic [FW-1:0] hit_idx;
    logic [FW-1:0] hit_mem [FIFO_DEPTH];

    always_comb begin
        filt_pass = 1'b0;
        hit_idx   = '0;
        for (int n = NUM_FILT - 1; n >= 0; n--) begin
            if (filt_en[n] && filt_ide[n] == ide &&
                ((id ^ filt_id[n*29 +: 29]) & filt_mask[n*29 +: 29]) == 29'd0) begin
                filt_pass = 1'b1;
                hit_idx   = FW'(n);
            end
        end
    end

    always_ff @(posedge clk_can) if (push) hit_mem[wr_ptr] <= hit_idx;
    assign rx_filt_hit = rx_valid ? hit_mem[rd_ptr] : '0;
`else
    assign filt_pass = 1'b1;
`endif
    logic unused_cfg;
    assign unused_cfg = ^NUM_FILT;

    assign full    = (level == (AW+1)'(FIFO_DEPTH));
    assign rx_valid = (level != '0);
    assign pop     = rx_valid && rx_ready;
    assign push    = commit && filt_pass && (!full || pop);
    assign ovf_set = commit && filt_pass && full && !pop;

    always_ff @(posedge clk_can) begin
        if (rst) begin
            wr_ptr <= '0; rd_ptr <= '0; level <= '0; rx_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + (AW+1)'(push) - (AW+1)'(pop);
            if (ovf_set)      rx_overflow <= 1'b1;
            else if (ovf_clr) rx_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk_can) if (push) mem[wr_ptr] <= '{id: id, ide: ide, rtr: rtr, dlc: dlc, data: data};

    assign head       = rx_valid ? mem[rd_ptr] : '0;
    assign rx_id      = head.id;
    assign rx_ide     = head.ide;
    assign rx_rtr     = head.rtr;
    assign rx_dlc     = head.dlc;
    assign rx_data    = head.data;
    assign fifo_level = level;
endmodule

// File: tb/tb_can_rx_frame_buffer.sv
// Directed bench for can_rx_frame_buffer: encodes frames (CRC + stuffing), checks decode, errors and FIFO.
module tb_can_rx_frame_buffer;
    localparam int DEPTH = 4;
    localparam int NF    = 4;

    logic        clk_can = 1'b0;
    logic        rst = 1'b1, bit_en = 1'b0, rx_bit = 1'b1, rx_ready = 1'b0, ovf_clr = 1'b0;
    logic        ack_drive, rx_valid, rx_ide, rx_rtr, rx_overflow, err_stuff, err_crc, err_form;
    logic [28:0] rx_id;
    logic [3:0]  rx_dlc;
    logic [63:0] rx_data;
    logic [$clog2(DEPTH):0] fifo_level;
`ifdef CAN_RX_ACCEPT_FILTER_EN
    logic [NF-1:0]    filt_en = '0, filt_ide = '0;
    logic [NF*29-1:0] filt_id = '0, filt_mask = '0;
    logic [$clog2(NF)-1:0] rx_filt_hit;
`endif

    always #5 clk_can = ~clk_can;

    can_rx_frame_buffer #(.FIFO_DEPTH(DEPTH), .NUM_FILT(NF)) dut (
        .clk_can(clk_can), .rst(rst), .bit_en(bit_en), .rx_bit(rx_bit), .ack_drive(ack_drive),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_id(rx_id), .rx_ide(rx_ide), .rx_rtr(rx_rtr),
        .rx_dlc(rx_dlc), .rx_data(rx_data), .fifo_level(fifo_level), .rx_overflow(rx_overflow),
        .ovf_clr(ovf_clr),
`ifdef CAN_RX_ACCEPT_FILTER_EN
        .filt_en(filt_en), .filt_ide(filt_ide), .filt_id(filt_id), .filt_mask(filt_mask),
        .rx_filt_hit(rx_filt_hit),
`endif
        .err_stuff(err_stuff), .err_crc(err_crc), .err_form(err_form));

    int n_cmp = 0, n_bad = 0;
    int ack_cyc = 0, stuff_cyc = 0, crc_cyc = 0, form_cyc = 0;
    int a0, s0, c0, f0;
    bit fr[$];
    int commit_idx;

    always @(negedge clk_can) begin
        if (ack_drive) ack_cyc++;
        if (err_stuff) stuff_cyc++;
        if (err_crc)   crc_cyc++;
        if (err_form)  form_cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [14:0] crc_step(input logic [14:0] c, input bit b);
        logic fb;
        fb = c[14] ^ b;
        return {c[13:0], 1'b0} ^ (fb ? 15'h4599 : 15'h0000);
    endfunction

    task automatic build(input logic [28:0] id, input bit ide, input bit rtr, input logic [3:0] dlc,
                         input logic [63:0] data, input bit flip);
        bit raw[$];
        logic [14:0] crc;
        int nb, run_n;
        bit run_v;
        raw = {};
        raw.push_back(1'b0);
        if (!ide) begin
            for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
            raw.push_back(rtr); raw.push_back(1'b0); raw.push_back(1'b0);
        end else begin
            for (int i = 28; i >= 18; i--) raw.push_back(id[i]);
            raw.push_back(1'b1); raw.push_back(1'b1);
            for (int i = 17; i >= 0; i--) raw.push_back(id[i]);
            raw.push_back(rtr); raw.push_back(1'b0); raw.push_back(1'b0);
        end
        for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
        nb = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
        for (int i = 0; i < nb * 8; i++) raw.push_back(data[63 - i]);
        crc = '0;
        foreach (raw[k]) crc = crc_step(crc, raw[k]);
        if (flip) crc[0] = ~crc[0];
        for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
        fr = {};
        run_v = 1'b0; run_n = 0;
        foreach (raw[k]) begin
            fr.push_back(raw[k]);
            if (raw[k] == run_v) run_n++;
            else begin run_v = raw[k]; run_n = 1; end
            if (run_n == 5) begin
                fr.push_back(~run_v);
                run_v = ~run_v; run_n = 1;
            end
        end
        commit_idx = fr.size() + 3 + 5;
        repeat (13) fr.push_back(1'b1);
    endtask

    task automatic send_bit(input bit b, input bit pop);
        rx_bit = b; bit_en = 1'b1; rx_ready = pop;
        @(posedge clk_can); #1;
        bit_en = 1'b0; rx_ready = 1'b0;
        repeat (3) @(posedge clk_can);
        #1;
    endtask

    task automatic send(input int limit, input bit pop_commit);
        for (int k = 0; k < fr.size() && k < limit; k++) send_bit(fr[k], pop_commit && k == commit_idx);
    endtask

    task automatic snap();
        a0 = ack_cyc; s0 = stuff_cyc; c0 = crc_cyc; f0 = form_cyc;
    endtask

    task automatic pop_one();
        rx_ready = 1'b1;
        @(posedge clk_can); #1;
        rx_ready = 1'b0;
    endtask

    typedef struct {
        logic [28:0] id; bit ide; bit rtr; logic [3:0] dlc; logic [63:0] data; bit flip;
        bit stored; logic [63:0] exp_data;
    } vec_t;
    vec_t vecs[7];

    initial begin
        vecs[0] = '{29'h123, 0, 0, 4'd2, 64'hA55A_0000_0000_0000, 0, 1, 64'hA55A_0000_0000_0000};
        vecs[1] = '{29'h12345678, 1, 1, 4'd4, 64'hDEAD_BEEF_0000_0000, 0, 1, 64'h0};
        vecs[2] = '{29'h123, 0, 0, 4'd2, 64'hA55A_0000_0000_0000, 1, 0, 64'h0};
        vecs[3] = '{29'h7FF, 0, 0, 4'd8, 64'h0123_4567_89AB_CDEF, 0, 1, 64'h0123_4567_89AB_CDEF};
        vecs[4] = '{29'h000, 0, 0, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 64'h0};
        vecs[5] = '{29'h1FFFFFFF, 1, 0, 4'd15, 64'h1122_3344_5566_7788, 0, 1, 64'h1122_3344_5566_7788};
        vecs[6] = '{29'h555, 0, 0, 4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 64'hFF00_0000_0000_0000};
`ifdef CAN_RX_ACCEPT_FILTER_EN
        filt_en = 4'b0011; filt_ide = 4'b0010;
`endif
        repeat (3) @(posedge clk_can);
        #1 rst = 1'b0;
        check("reset rx_valid", 64'(rx_valid), 64'd0);
        check("reset fifo_level", 64'(fifo_level), 64'd0);
        check("reset ack_drive", 64'(ack_drive), 64'd0);
        check("reset rx_overflow", 64'(rx_overflow), 64'd0);
        check("reset rx_id", 64'(rx_id), 64'd0);
        check("reset rx_data", rx_data, 64'd0);
        repeat (11) send_bit(1'b1, 1'b0);

        for (int v = 0; v < 7; v++) begin
            snap();
            build(vecs[v].id, vecs[v].ide, vecs[v].rtr, vecs[v].dlc, vecs[v].data, vecs[v].flip);
            send(fr.size(), 1'b0);
            check($sformatf("v%0d ack cycles", v), 64'(ack_cyc - a0), vecs[v].stored ? 64'd4 : 64'd0);
            check($sformatf("v%0d err_crc", v), 64'(crc_cyc - c0), vecs[v].flip ? 64'd1 : 64'd0);
            check($sformatf("v%0d err_stuff/form", v), 64'(stuff_cyc - s0 + form_cyc - f0), 64'd0);
            check($sformatf("v%0d fifo_level", v), 64'(fifo_level), 64'(vecs[v].stored));
            if (vecs[v].stored) begin
                check($sformatf("v%0d rx_valid", v), 64'(rx_valid), 64'd1);
                check($sformatf("v%0d rx_id", v), 64'(rx_id), 64'(vecs[v].id));
                check($sformatf("v%0d rx_ide", v), 64'(rx_ide), 64'(vecs[v].ide));
                check($sformatf("v%0d rx_rtr", v), 64'(rx_rtr), 64'(vecs[v].rtr));
                check($sformatf("v%0d rx_dlc", v), 64'(rx_dlc), 64'(vecs[v].dlc));
                check($sformatf("v%0d rx_data", v), rx_data, vecs[v].exp_data);
                pop_one();
                check($sformatf("v%0d level after pop", v), 64'(fifo_level), 64'd0);
            end
        end

        // Stuff error inside ID, then recovery needs 11 recessive bits.
        snap();
        repeat (7) send_bit(1'b0, 1'b0);
        check("stuff err pulse", 64'(stuff_cyc - s0), 64'd1);
        repeat (10) send_bit(1'b1, 1'b0);
        build(29'h321, 0, 0, 4'd1, 64'h4200_0000_0000_0000, 0);
        snap();
        send(fr.size(), 1'b0);
        check("frame during ERR not stored", 64'(fifo_level), 64'd0);
        check("frame during ERR not acked", 64'(ack_cyc - a0), 64'd0);
        send(fr.size(), 1'b0);
        check("frame after ERR stored", 64'(fifo_level), 64'd1);
        check("frame after ERR id", 64'(rx_id), 64'h321);
        pop_one();

        // Reset mid-DATA discards the frame.
        build(29'h123, 0, 0, 4'd2, 64'hA55A_0000_0000_0000, 0);
        send(24, 1'b0);
        rst = 1'b1;
        @(posedge clk_can); #1;
        rst = 1'b0;
        rx_bit = 1'b1;
        repeat (12) send_bit(1'b1, 1'b0);
        check("rst mid-frame level", 64'(fifo_level), 64'd0);
        send(fr.size(), 1'b0);
        check("after rst frame stored", 64'(fifo_level), 64'd1);
        pop_one();

        // Overflow with a full FIFO, then ovf_clr.
        for (int f = 0; f < 5; f++) begin
            build(29'(29'h101 + f), 0, 0, 4'd1, {8'(f), 56'd0}, 0);
            send(fr.size(), 1'b0);
        end
        check("ovf level", 64'(fifo_level), 64'd4);
        check("ovf sticky", 64'(rx_overflow), 64'd1);
        for (int f = 0; f < 4; f++) begin
            check($sformatf("ovf pop%0d id", f), 64'(rx_id), 64'(29'h101 + f));
            pop_one();
        end
        check("ovf drained", 64'(rx_valid), 64'd0);
        ovf_clr = 1'b1;
        @(posedge clk_can); #1;
        ovf_clr = 1'b0;
        check("ovf cleared", 64'(rx_overflow), 64'd0);

        // Full FIFO with a pop on the commit cycle accepts the new frame.
        for (int f = 0; f < 5; f++) begin
            build(29'(29'h111 + f), 0, 0, 4'd1, {8'(f), 56'd0}, 0);
            send(fr.size(), f == 4);
        end
        check("pop-commit level", 64'(fifo_level), 64'd4);
        check("pop-commit no ovf", 64'(rx_overflow), 64'd0);
        for (int f = 0; f < 4; f++) begin
            check($sformatf("pop-commit pop%0d id", f), 64'(rx_id), 64'(29'h112 + f));
            pop_one();
        end

`ifdef CAN_RX_ACCEPT_FILTER_EN
        filt_en = 4'b0001; filt_ide = 4'b0000;
        filt_id[28:0] = 29'h120; filt_mask[28:0] = 29'h7F0;
        build(29'h123, 0, 0, 4'd2, 64'hA55A_0000_0000_0000, 0);
        send(fr.size(), 1'b0);
        check("filt hit stored", 64'(fifo_level), 64'd1);
        check("filt hit index", 64'(rx_filt_hit), 64'd0);
        pop_one();
        snap();
        build(29'h223, 0, 0, 4'd2, 64'hA55A_0000_0000_0000, 0);
        send(fr.size(), 1'b0);
        check("filt miss acked", 64'(ack_cyc - a0), 64'd4);
        check("filt miss not stored", 64'(fifo_level), 64'd0);
        check("filt miss no ovf", 64'(rx_overflow), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
